// File: rtl/vc_noc_pkg.sv
// Shared constants, FSM state type and XY route helper for the VC NoC
// input buffer.
package vc_noc_pkg;

    // Flit type bit positions (one-hot; HOF|EOF is a single-flit packet)
    localparam int HOF = 0;
    localparam int BOF = 1;
    localparam int EOF = 2;

    // One-hot output port indices
    localparam int DIR_S  = 0;
    localparam int DIR_W  = 1;
    localparam int DIR_N  = 2;
    localparam int DIR_E  = 3;
    localparam int DIR_L  = 4;
    localparam int SN_DEF = 5;

    // Per-VC packet state
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ROUTE  = 2'd1,
        ST_ACTIVE = 2'd2
    } vc_state_e;

    // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
    function automatic logic [SN_DEF-1:0] xy_route(
        input logic [7:0] dx,
        input logic [7:0] dy,
        input logic [7:0] ax,
        input logic [7:0] ay
    );
        logic [SN_DEF-1:0] r;
        r = '0;
        if (dx > ax)      r[DIR_E] = 1'b1;
        else if (dx < ax) r[DIR_W] = 1'b1;
        else if (dy > ay) r[DIR_N] = 1'b1;
        else if (dy < ay) r[DIR_S] = 1'b1;
        else              r[DIR_L] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/vc_inpbuf_sync_if.sv
// Link and router-side signals of one input buffer, grouped per direction.
//
// Handshake rules, all sampled on the rising clock edge:
//  - Upstream write: divc one-hot selects the VC receiving di/dit; there is
//    no ready, flow control is by credits (cor pulses once per flit freed).
//  - VC allocation: vcr holds a one-hot route while waiting; a vcra pulse on
//    that VC is the grant, after which vcr drops.
//  - Switch traversal: swr[0] is "head valid"; doa while swr[0]=1 pops the
//    head at that edge. doa without a valid head has no effect.
// The head data bus is named dout because "do" is a reserved word.
interface vc_inpbuf_sync_if #(
    parameter int DW  = 32,
    parameter int VCN = 2,
    parameter int SN  = 5,
    parameter int FT  = 3
);
    logic [DW-1:0]     di;
    logic [FT-1:0]     dit;
    logic [VCN-1:0]    divc;
    logic [VCN-1:0]    cor;
    logic [VCN*DW-1:0] dout;
    logic [VCN*FT-1:0] dot;
    logic [VCN*SN-1:0] dortg;
    logic [VCN-1:0]    doa;
    logic [VCN*SN-1:0] vcr;
    logic [VCN-1:0]    vcra;
    logic [VCN*2-1:0]  swr;

    // Upstream link plus allocators/crossbar: drives flits, grants and pops
    modport master (
        output di, dit, divc, doa, vcra,
        input  cor, dout, dot, dortg, vcr, swr
    );

    // The input buffer itself
    modport slave (
        input  di, dit, divc, doa, vcra,
        output cor, dout, dot, dortg, vcr, swr
    );
endinterface

// File: rtl/vc_fifo.sv
// Register FIFO for one virtual channel. Head is always presented on rdata;
// a write while full is accepted only when a read happens in the same cycle.
module vc_fifo #(
    parameter int W     = 35,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [W-1:0]  wdata,
    input  logic          rd,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          rd_ok;
    logic          wr_ok;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rd_ok = rd && !empty;
    assign wr_ok = wr && (!full || rd_ok);
    assign rdata = mem[rp];

    // Storage array; stale entries are harmless because pointers gate visibility
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) mem[wp] <= wdata;
    end

    // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr_ok) wp <= wp + AW'(1);
            if (rd_ok) rp <= rp + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/vc_inpbuf_sync.sv
// Synchronous router input buffer: per-VC FIFOs, XY route computation on
// head flits, per-VC packet FSM driving VC and switch allocator requests,
// credit return on every pop, sticky overflow/protocol error flags.
module vc_inpbuf_sync
    import vc_noc_pkg::*;
#(
    parameter int DW    = 32,
    parameter int VCN   = 2,
    parameter int DEPTH = 4,
    parameter int SN    = SN_DEF,
    parameter int FT    = 3,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    vc_inpbuf_sync_if.slave      bus,
    input  logic [7:0]           addrx,
    input  logic [7:0]           addry,
    output logic [1:0]           err,
    output logic [2*VCN-1:0]     dbg_state,
    output logic [VCN*CW-1:0]    dbg_count
);
    logic              wr_one;
    logic              wr_multi;
    logic [VCN-1:0]    ovf;
    logic [VCN-1:0]    perr;
    logic [VCN-1:0]    cor_v;
    logic [VCN*DW-1:0] dout_v;
    logic [VCN*FT-1:0] dot_v;
    logic [VCN*SN-1:0] dortg_v;
    logic [VCN*SN-1:0] vcr_v;
    logic [VCN*2-1:0]  swr_v;

    assign wr_one   = $onehot(bus.divc);
    assign wr_multi = (bus.divc != '0) && !wr_one;

    for (genvar v = 0; v < VCN; v++) begin : g_vc
        logic [DW+FT-1:0] rdata;
        logic             empty;
        logic             full;
        logic             wr;
        logic             rd;
        logic [CW-1:0]    count;
        logic [DW-1:0]    hd;
        logic [FT-1:0]    ht;
        vc_state_e        state;
        logic [SN-1:0]    vcr_q;
        logic [SN-1:0]    rtg_q;
        logic             cor_q;

        // Head is forced to zero when the FIFO holds nothing
        assign hd = empty ? '0 : rdata[DW+FT-1:FT];
        assign ht = empty ? '0 : rdata[FT-1:0];

        // Pop on crossbar accept in ACTIVE, or discard a stray non-head flit in IDLE
        assign rd = !empty &&
                    (((state == ST_ACTIVE) && bus.doa[v]) ||
                     ((state == ST_IDLE) && !ht[HOF]));
        assign wr = wr_one && bus.divc[v] && (!full || rd);

        assign ovf[v]  = wr_one && bus.divc[v] && full && !rd;
        assign perr[v] = (state == ST_IDLE) && !empty && !ht[HOF];

        vc_fifo #(
            .W     (DW + FT),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .wr    (wr),
            .wdata ({bus.di, bus.dit}),
            .rd    (rd),
            .rdata (rdata),
            .empty (empty),
            .full  (full),
            .count (count)
        );

        // Packet FSM with registered route request, latched route and credit pulse
        always_ff @(posedge clk) begin
            if (rst) begin
                state <= ST_IDLE;
                vcr_q <= '0;
                rtg_q <= '0;
                cor_q <= 1'b0;
            end else begin
                cor_q <= rd;
                case (state)
                    ST_IDLE: begin
                        if (!empty && ht[HOF]) begin
                            state <= ST_ROUTE;
                            vcr_q <= xy_route(hd[7:0], hd[15:8], addrx, addry);
                        end
                    end
                    ST_ROUTE: begin
                        if (bus.vcra[v]) begin
                            state <= ST_ACTIVE;
                            rtg_q <= vcr_q;
                            vcr_q <= '0;
                        end
                    end
                    ST_ACTIVE: begin
                        if (rd && ht[EOF]) begin
                            state <= ST_IDLE;
                            rtg_q <= '0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        vcr_q <= '0;
                        rtg_q <= '0;
                    end
                endcase
            end
        end

        assign cor_v[v]              = cor_q;
        assign dout_v[v*DW +: DW]    = hd;
        assign dot_v[v*FT +: FT]     = ht;
        assign dortg_v[v*SN +: SN]   = rtg_q;
        assign vcr_v[v*SN +: SN]     = vcr_q;
        assign swr_v[2*v +: 2]       = (state == ST_ACTIVE) ? {ht[EOF], !empty} : 2'b00;
        assign dbg_state[2*v +: 2]   = state;
        assign dbg_count[v*CW +: CW] = count;
    end

    assign bus.cor   = cor_v;
    assign bus.dout  = dout_v;
    assign bus.dot   = dot_v;
    assign bus.dortg = dortg_v;
    assign bus.vcr   = vcr_v;
    assign bus.swr   = swr_v;

    // Sticky error flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 2'b00;
        end else begin
            if (|ovf)               err[0] <= 1'b1;
            if (wr_multi || |perr)  err[1] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vc_inpbuf_sync.sv
// Bench for vc_inpbuf_sync: scenario tasks with inline checks and a per-VC
// expected-flit queue filled on write and consumed on pop.
module tb_vc_inpbuf_sync;
    localparam int DW = 32;
    localparam int VCN = 2;
    localparam int SN = 5;
    localparam int FT = 3;
    localparam int DEPTH = 4;
    localparam int CW = 3;
    localparam int W = DW + FT;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ROUTE = 2'd1;
    localparam logic [1:0] S_ACTIVE = 2'd2;
    localparam logic [SN-1:0] R_S = 5'b00001;
    localparam logic [SN-1:0] R_W = 5'b00010;
    localparam logic [SN-1:0] R_N = 5'b00100;
    localparam logic [SN-1:0] R_E = 5'b01000;
    localparam logic [SN-1:0] R_L = 5'b10000;

    logic clk;
    logic rst;
    logic [7:0] addrx;
    logic [7:0] addry;
    logic [1:0] err;
    logic [2*VCN-1:0] dbg_state;
    logic [VCN*CW-1:0] dbg_count;

    vc_inpbuf_sync_if #(.DW(DW), .VCN(VCN), .SN(SN), .FT(FT)) bus ();

    vc_inpbuf_sync #(.DW(DW), .VCN(VCN), .DEPTH(DEPTH), .SN(SN), .FT(FT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .addrx     (addrx),
        .addry     (addry),
        .err       (err),
        .dbg_state (dbg_state),
        .dbg_count (dbg_count)
    );

    int errors = 0;
    int checks = 0;
    int cor_cnt [VCN];
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    logic [SN-1:0] exp_rt [VCN];

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // credit pulse counter, sampled on the falling edge
    initial begin
        for (int v = 0; v < VCN; v++) cor_cnt[v] = 0;
    end
    always @(negedge clk) begin
        for (int v = 0; v < VCN; v++) if (bus.cor[v] === 1'b1) cor_cnt[v]++;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int v, input logic [W-1:0] f);
        if (v == 0) exp_q0.push_back(f);
        else        exp_q1.push_back(f);
    endtask

    task automatic pop_exp(input int v, output logic [W-1:0] f, output bit ok);
        ok = 1'b1;
        f = '0;
        if (v == 0) begin
            if (exp_q0.size() == 0) ok = 1'b0; else f = exp_q0.pop_front();
        end else begin
            if (exp_q1.size() == 0) ok = 1'b0; else f = exp_q1.pop_front();
        end
    endtask

    function automatic logic [DW-1:0] head_data(input logic [7:0] x, input logic [7:0] y);
        logic [15:0] hi;
        hi = 16'($urandom_range(0, 65535));
        return {hi, y, x};
    endfunction

    task automatic write_flit(input int v, input logic [DW-1:0] d, input logic [FT-1:0] t,
                              input bit keep);
        bus.di = d;
        bus.dit = t;
        bus.divc = '0;
        bus.divc[v] = 1'b1;
        if (keep) push_exp(v, {d, t});
        tick();
        bus.divc = '0;
    endtask

    // Drives grants and pops until every expected flit is drained and all VCs idle
    task automatic run_vcs(input string name);
        bit rt_chk [VCN];
        bit rg_chk [VCN];
        bit ok;
        int cyc;
        logic [1:0] st;
        logic [W-1:0] head;
        logic [W-1:0] want;
        for (int v = 0; v < VCN; v++) begin
            rt_chk[v] = 1'b0;
            rg_chk[v] = 1'b0;
        end
        cyc = 0;
        while (!(exp_q0.size() == 0 && exp_q1.size() == 0 && dbg_state == '0) && cyc < 80) begin
            for (int v = 0; v < VCN; v++) begin
                st = dbg_state[2*v +: 2];
                bus.vcra[v] = 1'b0;
                bus.doa[v] = 1'b0;
                if (st == S_ROUTE) begin
                    if (!rt_chk[v]) begin
                        checks++;
                        if (bus.vcr[v*SN +: SN] !== exp_rt[v]) begin
                            errors++;
                            $display("FAIL %s vcr[%0d]: got %b want %b", name, v, bus.vcr[v*SN +: SN], exp_rt[v]);
                        end
                        rt_chk[v] = 1'b1;
                    end
                    bus.vcra[v] = 1'b1;
                end else if (st == S_ACTIVE) begin
                    if (!rg_chk[v]) begin
                        checks++;
                        if (bus.dortg[v*SN +: SN] !== exp_rt[v]) begin
                            errors++;
                            $display("FAIL %s dortg[%0d]: got %b want %b", name, v, bus.dortg[v*SN +: SN], exp_rt[v]);
                        end
                        rg_chk[v] = 1'b1;
                    end
                    if (bus.swr[2*v] === 1'b1) begin
                        head = {bus.dout[v*DW +: DW], bus.dot[v*FT +: FT]};
                        pop_exp(v, want, ok);
                        checks++;
                        if (!ok || head !== want) begin
                            errors++;
                            $display("FAIL %s head[%0d]: got %h want %h (expected present=%0d)", name, v, head, want, ok);
                        end
                        checks++;
                        if (bus.swr[2*v+1] !== want[2]) begin
                            errors++;
                            $display("FAIL %s swr_eof[%0d]: got %b want %b", name, v, bus.swr[2*v+1], want[2]);
                        end
                        bus.doa[v] = 1'b1;
                    end
                end
            end
            tick();
            cyc++;
        end
        bus.vcra = '0;
        bus.doa = '0;
        checks++;
        if (cyc >= 80) begin
            errors++;
            $display("FAIL %s drain_timeout: got %0d cycles want <80", name, cyc);
        end
    endtask

    // scenario tasks
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.cor !== '0 || bus.vcr !== '0 || bus.swr !== '0 || bus.dortg !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got cor=%b vcr=%b swr=%b dortg=%b want all 0", bus.cor, bus.vcr, bus.swr, bus.dortg);
        end
        checks++;
        if (err !== 2'b00 || bus.dout !== '0 || bus.dot !== '0) begin
            errors++;
            $display("FAIL reset_data: got err=%b do=%h dot=%b want 0", err, bus.dout, bus.dot);
        end
        checks++;
        if (dbg_state !== '0 || dbg_count !== '0) begin
            errors++;
            $display("FAIL reset_state: got state=%b count=%b want 0", dbg_state, dbg_count);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_flit();
        logic [DW-1:0] d;
        logic [W-1:0] want;
        bit ok;
        bit seen;
        int c0;
        d = {16'hBEEF, 8'h02, 8'h02};
        write_flit(0, d, 3'b101, 1'b1);
        checks++;
        if (bus.dout[DW-1:0] !== d || bus.dot[FT-1:0] !== 3'b101) begin
            errors++;
            $display("FAIL single_latency: got do=%h dot=%b want %h 101", bus.dout[DW-1:0], bus.dot[FT-1:0], d);
        end
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            if (bus.vcr[SN-1:0] !== '0) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen || bus.vcr[SN-1:0] !== R_L) begin
            errors++;
            $display("FAIL single_vcr: got %b want %b", bus.vcr[SN-1:0], R_L);
        end
        bus.vcra[0] = 1'b1;
        tick();
        bus.vcra[0] = 1'b0;
        checks++;
        if (bus.vcr[SN-1:0] !== '0 || bus.swr[1:0] !== 2'b11 || bus.dortg[SN-1:0] !== R_L) begin
            errors++;
            $display("FAIL single_active: got vcr=%b swr=%b dortg=%b want 00000 11 %b", bus.vcr[SN-1:0], bus.swr[1:0], bus.dortg[SN-1:0], R_L);
        end
        pop_exp(0, want, ok);
        checks++;
        if (!ok || {bus.dout[DW-1:0], bus.dot[FT-1:0]} !== want) begin
            errors++;
            $display("FAIL single_head: got %h want %h", {bus.dout[DW-1:0], bus.dot[FT-1:0]}, want);
        end
        c0 = cor_cnt[0];
        bus.doa[0] = 1'b1;
        tick();
        bus.doa[0] = 1'b0;
        checks++;
        if (bus.cor[0] !== 1'b1 || dbg_state[1:0] !== S_IDLE || bus.dortg[SN-1:0] !== '0) begin
            errors++;
            $display("FAIL single_pop: got cor=%b state=%0d dortg=%b want 1 0 00000", bus.cor[0], dbg_state[1:0], bus.dortg[SN-1:0]);
        end
        tick();
        checks++;
        if (bus.cor[0] !== 1'b0 || cor_cnt[0] - c0 != 1) begin
            errors++;
            $display("FAIL single_cor_pulse: got cor=%b pulses=%0d want 0 1", bus.cor[0], cor_cnt[0] - c0);
        end
    endtask

    task automatic test_xy_route();
        logic [7:0] xs [5] = '{8'd5, 8'd0, 8'd2, 8'd2, 8'd2};
        logic [7:0] ys [5] = '{8'd2, 8'd2, 8'd7, 8'd0, 8'd2};
        logic [SN-1:0] rs [5] = '{R_E, R_W, R_N, R_S, R_L};
        for (int i = 0; i < 5; i++) begin
            write_flit(0, head_data(xs[i], ys[i]), 3'b101, 1'b1);
            exp_rt[0] = rs[i];
            run_vcs($sformatf("xy%0d", i));
        end
    endtask

    task automatic test_overflow();
        int c1;
        bit seen;
        bit ok;
        logic [W-1:0] want;
        c1 = cor_cnt[1];
        write_flit(1, head_data(8'd2, 8'd2), 3'b001, 1'b1);
        for (int i = 0; i < 3; i++) write_flit(1, DW'($urandom), 3'b010, 1'b1);
        checks++;
        if (dbg_count[CW +: CW] !== 3'd4 || err[0] !== 1'b0) begin
            errors++;
            $display("FAIL ovf_fill: got count=%0d err0=%b want 4 0", dbg_count[CW +: CW], err[0]);
        end
        write_flit(1, DW'($urandom), 3'b100, 1'b0);
        checks++;
        if (err[0] !== 1'b1 || dbg_count[CW +: CW] !== 3'd4) begin
            errors++;
            $display("FAIL ovf_drop: got err0=%b count=%0d want 1 4", err[0], dbg_count[CW +: CW]);
        end
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            if (bus.vcr[SN +: SN] !== '0) seen = 1'b1;
            else tick();
        end
        checks++;
        if (!seen || bus.vcr[SN +: SN] !== R_L) begin
            errors++;
            $display("FAIL ovf_vcr: got %b want %b", bus.vcr[SN +: SN], R_L);
        end
        bus.vcra[1] = 1'b1;
        tick();
        bus.vcra[1] = 1'b0;
        checks++;
        if (dbg_state[3:2] !== S_ACTIVE || bus.swr[3:2] !== 2'b01) begin
            errors++;
            $display("FAIL ovf_active: got state=%0d swr=%b want 2 01", dbg_state[3:2], bus.swr[3:2]);
        end
        pop_exp(1, want, ok);
        checks++;
        if (!ok || {bus.dout[DW +: DW], bus.dot[FT +: FT]} !== want) begin
            errors++;
            $display("FAIL ovf_head: got %h want %h", {bus.dout[DW +: DW], bus.dot[FT +: FT]}, want);
        end
        bus.doa[1] = 1'b1;
        write_flit(1, DW'($urandom), 3'b100, 1'b1);
        bus.doa[1] = 1'b0;
        checks++;
        if (dbg_count[CW +: CW] !== 3'd4 || bus.cor[1] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_wr_pop: got count=%0d cor1=%b want 4 1", dbg_count[CW +: CW], bus.cor[1]);
        end
        tick();
        checks++;
        if (bus.cor[1] !== 1'b0 || cor_cnt[1] - c1 != 1) begin
            errors++;
            $display("FAIL ovf_one_credit: got cor1=%b pulses=%0d want 0 1", bus.cor[1], cor_cnt[1] - c1);
        end
        exp_rt[1] = R_L;
        run_vcs("ovf_drain");
        tick();
        tick();
        checks++;
        if (cor_cnt[1] - c1 != 5) begin
            errors++;
            $display("FAIL ovf_total_credit: got %0d want 5", cor_cnt[1] - c1);
        end
    endtask

    task automatic test_interleave();
        int c0;
        int c1;
        c0 = cor_cnt[0];
        c1 = cor_cnt[1];
        write_flit(0, head_data(8'd5, 8'd2), 3'b001, 1'b1);
        write_flit(1, head_data(8'd2, 8'd0), 3'b001, 1'b1);
        write_flit(0, DW'($urandom), 3'b010, 1'b1);
        write_flit(1, DW'($urandom), 3'b100, 1'b1);
        write_flit(0, DW'($urandom), 3'b100, 1'b1);
        exp_rt[0] = R_E;
        exp_rt[1] = R_S;
        run_vcs("interleave");
        tick();
        tick();
        checks++;
        if (cor_cnt[0] - c0 != 3 || cor_cnt[1] - c1 != 2) begin
            errors++;
            $display("FAIL interleave_credit: got %0d/%0d want 3/2", cor_cnt[0] - c0, cor_cnt[1] - c1);
        end
    endtask

    task automatic test_protocol_error();
        int c0;
        bit seen;
        c0 = cor_cnt[0];
        checks++;
        if (err !== 2'b01) begin
            errors++;
            $display("FAIL proto_before: got err=%b want 01", err);
        end
        write_flit(0, DW'($urandom), 3'b010, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (bus.vcr[SN-1:0] !== '0) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen || err !== 2'b11) begin
            errors++;
            $display("FAIL proto_err: got vcr_seen=%0d err=%b want 0 11", seen, err);
        end
        checks++;
        if (cor_cnt[0] - c0 != 1 || dbg_count[CW-1:0] !== '0 || dbg_state[1:0] !== S_IDLE) begin
            errors++;
            $display("FAIL proto_discard: got pulses=%0d count=%0d state=%0d want 1 0 0", cor_cnt[0] - c0, dbg_count[CW-1:0], dbg_state[1:0]);
        end
    endtask

    task automatic test_reset_mid_packet();
        int c0;
        bit seen;
        write_flit(0, head_data(8'd2, 8'd2), 3'b001, 1'b1);
        write_flit(0, DW'($urandom), 3'b010, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            if (dbg_state[1:0] == S_ROUTE) seen = 1'b1;
            else tick();
        end
        bus.vcra[0] = 1'b1;
        tick();
        bus.vcra[0] = 1'b0;
        checks++;
        if (!seen || dbg_state[1:0] !== S_ACTIVE || dbg_count[CW-1:0] !== 3'd2) begin
            errors++;
            $display("FAIL midrst_setup: got state=%0d count=%0d want 2 2", dbg_state[1:0], dbg_count[CW-1:0]);
        end
        c0 = cor_cnt[0];
        rst = 1'b1;
        bus.doa[0] = 1'b1;
        tick();
        rst = 1'b0;
        bus.doa[0] = 1'b0;
        checks++;
        if (bus.cor !== '0 || dbg_count !== '0 || dbg_state !== '0) begin
            errors++;
            $display("FAIL midrst_state: got cor=%b count=%b state=%b want 0", bus.cor, dbg_count, dbg_state);
        end
        checks++;
        if (bus.dout !== '0 || bus.dot !== '0 || bus.vcr !== '0 || bus.swr !== '0 || bus.dortg !== '0 || err !== 2'b00) begin
            errors++;
            $display("FAIL midrst_outputs: got do=%h dot=%b vcr=%b swr=%b dortg=%b err=%b want 0", bus.dout, bus.dot, bus.vcr, bus.swr, bus.dortg, err);
        end
        tick();
        tick();
        checks++;
        if (cor_cnt[0] != c0) begin
            errors++;
            $display("FAIL midrst_credit: got %0d pulses want 0", cor_cnt[0] - c0);
        end
        exp_q0.delete();
    endtask

    task automatic test_multi_vc_write();
        bus.di = DW'($urandom);
        bus.dit = 3'b001;
        bus.divc = 2'b11;
        tick();
        bus.divc = '0;
        tick();
        checks++;
        if (err !== 2'b10 || dbg_count !== '0) begin
            errors++;
            $display("FAIL multi_vc: got err=%b count=%b want 10 0", err, dbg_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        addrx = 8'd2;
        addry = 8'd2;
        bus.di = '0;
        bus.dit = '0;
        bus.divc = '0;
        bus.doa = '0;
        bus.vcra = '0;
        test_reset();
        test_single_flit();
        test_xy_route();
        test_overflow();
        test_interleave();
        test_protocol_error();
        test_reset_mid_packet();
        test_multi_vc_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
